// File: rtl/sram_like_resp_pkg.sv
// rtl/sram_like_resp_pkg.sv - shared types and defaults for the SRAM-like responder
// Purpose: size encodings, default timing parameters and response payload layout
//          shared by sram_like_resp and resp_queue.
package sram_like_resp_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    localparam int DEF_LATENCY   = 2;
    localparam int DEF_OST_DEPTH = 2;

    // LATENCY is at most 7, so the per-entry countdown fits in 3 bits.
    localparam int CNT_W  = 3;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              is_wr;
        logic [DATA_W-1:0] rdata;
    } resp_payload_t;

endpackage

// File: rtl/resp_queue.sv
// rtl/resp_queue.sv - in-order outstanding-request queue with per-entry countdown
// Purpose: circular FIFO of DEPTH entries; each entry carries a payload and a
//          countdown loaded with LOAD on push and decremented (saturating) every cycle.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   push, push_data        enqueue request and payload (ignored while full)
//   pop                    dequeue head (ignored while empty)
//   head_data, head_zero   head payload, head countdown has reached zero
//   count, full, empty     occupancy status
module resp_queue
    import sram_like_resp_pkg::*;
#(
    parameter int                DEPTH = DEF_OST_DEPTH,
    parameter int                DW    = 33,
    parameter logic [CNT_W-1:0]  LOAD  = '0,
    localparam int               PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int               CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          head_zero,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0]    data_q [DEPTH];
    logic [CNT_W-1:0] cnt_q  [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = data_q[rd_ptr];
    assign head_zero = (cnt_q[rd_ptr] == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // Free slots also count down; harmless because a push reloads them.
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
            end
            if (do_push) begin
                cnt_q[wr_ptr] <= LOAD;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            data_q[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/sram_like_resp.sv
// rtl/sram_like_resp.sv - SRAM-like memory slave with fixed-latency in-order responses
// Purpose: word-addressed memory with byte-lane writes; each accepted request
//          returns a single-cycle data_ok exactly LATENCY cycles after acceptance.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req, wr, size, wstrb    request valid, write flag, access size (unused), byte enables
//   addr, wdata             byte address, write data
//   addr_ok                 request accepted this cycle when req=1
//   data_ok, rdata          response pulse and read data (zero when not a read response)
module sram_like_resp
    import sram_like_resp_pkg::*;
#(
    parameter int AW        = 10,
    parameter int LATENCY   = DEF_LATENCY,
    parameter int OST_DEPTH = DEF_OST_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int CW = $clog2(OST_DEPTH + 1);

    logic [31:0]   mem [2**AW];
    logic [AW-1:0] idx;
    logic          accept;
    resp_payload_t push_entry;
    resp_payload_t head_entry;
    logic          q_head_zero;
    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;
    logic          unused_bits;

    // Only the word index matters: byte offset and high bits alias, and size
    // is left to the initiator to interpret.
    assign idx         = addr[AW+1:2];
    assign unused_bits = ^{size, addr[31:AW+2], addr[1:0], q_count};

    // No bypass from a retiring entry: a full queue stalls for a cycle even
    // if the head is leaving.
    assign addr_ok = !reset && !q_full;
    assign accept  = req && addr_ok;

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // The read word is captured at acceptance, so it reflects writes from
    // earlier cycles but not the write (if any) accepted at the same edge.
    assign push_entry.is_wr = wr;
    assign push_entry.rdata = mem[idx];

    resp_queue #(
        .DEPTH (OST_DEPTH),
        .DW    ($bits(resp_payload_t)),
        .LOAD  (CNT_W'(LATENCY - 1))
    ) u_resp_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (push_entry),
        .pop       (data_ok),
        .head_data (head_entry),
        .head_zero (q_head_zero),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign data_ok = !q_empty && q_head_zero;
    assign rdata   = (data_ok && !head_entry.is_wr) ? head_entry.rdata : '0;

endmodule

// File: tb/tb_sram_like_resp.sv
// tb/tb_sram_like_resp.sv - scoreboard bench for sram_like_resp at LATENCY 2, 3 and 1
module tb_sram_like_resp;

    typedef struct {
        int          dut;
        int          cyc;
        logic        is_wr;
        logic [31:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       req;
    logic             wr;
    logic [1:0]       size;
    logic [3:0]       wstrb;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [2:0]       addr_ok;
    logic [2:0]       data_ok;
    logic [2:0][31:0] rdata;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   okcnt [3];
    int   lat_tab [3] = '{2, 3, 1};
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_like_resp u_dut0 (
        .clk(clk), .reset(reset), .req(req[0]), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0])
    );

    sram_like_resp #(.LATENCY(3), .OST_DEPTH(2)) u_dut1 (
        .clk(clk), .reset(reset), .req(req[1]), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1])
    );

    sram_like_resp #(.LATENCY(1)) u_dut2 (
        .clk(clk), .reset(reset), .req(req[2]), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok[2]), .data_ok(data_ok[2]), .rdata(rdata[2])
    );

    // Response monitor: every data_ok must match the oldest expectation of
    // that instance in cycle and (for reads) data.
    always @(negedge clk) begin
        int k;
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                if (data_ok[d]) begin
                    okcnt[d]++;
                    k = -1;
                    for (int j = 0; j < sb.size(); j++) begin
                        if (sb[j].dut == d) begin
                            k = j;
                            break;
                        end
                    end
                    checks++;
                    if (k < 0) begin
                        failures++;
                        $display("FAIL spurious_data_ok dut=%0d cyc=%0d", d, cyc);
                    end else begin
                        if (cyc != sb[k].cyc) begin
                            failures++;
                            $display("FAIL resp_cycle dut=%0d got=%0d want=%0d", d, cyc, sb[k].cyc);
                        end
                        if (!sb[k].is_wr) begin
                            checks++;
                            if (rdata[d] !== sb[k].data) begin
                                failures++;
                                $display("FAIL rdata dut=%0d got=%h want=%h", d, rdata[d], sb[k].data);
                            end
                        end
                        sb.delete(k);
                    end
                end
            end
        end
    end

    task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] wd, input logic [31:0] ex, output int acc);
        int n;
        n     = 0;
        wr    = w;
        addr  = a;
        wstrb = s;
        wdata = wd;
        size  = 2'($urandom_range(0, 2));
        req[d] = 1'b1;
        while (!addr_ok[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!addr_ok[d]) begin
            failures++;
            $display("FAIL accept_timeout dut=%0d addr=%h", d, a);
            req[d] = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        sb.push_back('{d, cyc + lat_tab[d], w, ex});
        @(negedge clk);
        req[d] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d want=0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (addr_ok[d] !== 1'b0 || data_ok[d] !== 1'b0 || rdata[d] !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d got=%b/%b/%h want=0/0/0",
                         d, addr_ok[d], data_ok[d], rdata[d]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (addr_ok !== 3'b111 || data_ok !== 3'b000) begin
            failures++;
            $display("FAIL reset_release got=%b/%b want=111/000", addr_ok, data_ok);
        end
    endtask

    task automatic test_write_read();
        int a;
        issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, a);
        checks++;
        if (data_ok[0] !== 1'b0) begin
            failures++;
            $display("FAIL wr_early_data_ok got=%b want=0", data_ok[0]);
        end
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, a);
        checks++;
        if (data_ok[0] !== 1'b1) begin
            failures++;
            $display("FAIL wr_data_ok_cycle got=%b want=1", data_ok[0]);
        end
        drain();
    endtask

    task automatic test_byte_lanes();
        int a;
        issue(0, 1'b1, 32'h10, 4'hF,    32'h11223344, 32'h0, a);
        issue(0, 1'b1, 32'h10, 4'b0010, 32'h0000AA00, 32'h0, a);
        issue(0, 1'b1, 32'h14, 4'hF,    32'hA0B0C0D0, 32'h0, a);
        issue(0, 1'b1, 32'h17, 4'b1001, 32'h11223344, 32'h0, a);
        issue(0, 1'b0, 32'h10, 4'h0,    32'h0, 32'h1122AA44, a);
        issue(0, 1'b0, 32'h15, 4'h0,    32'h0, 32'h11B0C044, a);
        drain();
    endtask

    task automatic test_outstanding();
        int a1, a2, a3, base;
        issue(1, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 32'h0, a1);
        issue(1, 1'b0, 32'h20, 4'h0, 32'h0, 32'hCAFEF00D, a2);
        checks++;
        if (addr_ok[1] !== 1'b0) begin
            failures++;
            $display("FAIL ost_full_addr_ok got=%b want=0", addr_ok[1]);
        end
        base = okcnt[1];
        issue(1, 1'b0, 32'h20, 4'h0, 32'h0, 32'hCAFEF00D, a3);
        checks++;
        if (a3 != a1 + 4) begin
            failures++;
            $display("FAIL ost_third_accept got=%0d want=%0d", a3, a1 + 4);
        end
        checks++;
        if (okcnt[1] - base != 2) begin
            failures++;
            $display("FAIL ost_resp_before_third got=%0d want=2", okcnt[1] - base);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int a1, a2, a3;
        issue(2, 1'b1, 32'h0, 4'hF, 32'h01010101, 32'h0, a1);
        issue(2, 1'b1, 32'h4, 4'hF, 32'h02020202, 32'h0, a1);
        issue(2, 1'b1, 32'h8, 4'hF, 32'h03030303, 32'h0, a1);
        issue(2, 1'b0, 32'h0, 4'h0, 32'h0, 32'h01010101, a1);
        issue(2, 1'b0, 32'h4, 4'h0, 32'h0, 32'h02020202, a2);
        issue(2, 1'b0, 32'h8, 4'h0, 32'h0, 32'h03030303, a3);
        checks++;
        if (a2 != a1 + 1 || a3 != a2 + 1) begin
            failures++;
            $display("FAIL b2b_accepts got=%0d,%0d,%0d want=consecutive", a1, a2, a3);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int a, base;
        issue(1, 1'b0, 32'h20, 4'h0, 32'h0, 32'hCAFEF00D, a);
        issue(1, 1'b0, 32'h20, 4'h0, 32'h0, 32'hCAFEF00D, a);
        base  = okcnt[1];
        reset = 1'b1;
        sb.delete();
        #1;
        checks++;
        if (addr_ok !== 3'b000 || data_ok !== 3'b000 || rdata[1] !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%b/%b/%h want=000/000/0", addr_ok, data_ok, rdata[1]);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (addr_ok[1] !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_addr_ok got=%b want=1", addr_ok[1]);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (okcnt[1] != base) begin
            failures++;
            $display("FAIL mid_reset_no_resp got=%0d want=0", okcnt[1] - base);
        end
    endtask

    task automatic test_alias();
        int a;
        issue(0, 1'b1, 32'h40,   4'hF, 32'h600DCAFE, 32'h0, a);
        issue(0, 1'b0, 32'h1040, 4'h0, 32'h0, 32'h600DCAFE, a);
        issue(0, 1'b0, 32'hFFFF_F042, 4'h0, 32'h0, 32'h600DCAFE, a);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req   = 3'b000;
        wr    = 1'b0;
        size  = 2'd0;
        wstrb = 4'h0;
        addr  = 32'h0;
        wdata = 32'h0;
        for (int d = 0; d < 3; d++) okcnt[d] = 0;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_outstanding();
        test_back_to_back();
        test_reset_mid();
        test_alias();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_like_resp.md
SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

Interface
REQ-001 The block SHALL have parameter AW, default 10, meaning log2 of memory depth in 32-bit words.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the cycles from request acceptance to data_ok; legal range 1..7.
REQ-003 The block SHALL have parameter OST_DEPTH, default 2, meaning the maximum number of outstanding requests.
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port req  input  1  request valid from the initiator.
REQ-007 The block SHALL have port wr  input  1  1 means write, 0 means read.
REQ-008 The block SHALL have port size  input  2  0 means byte, 1 means halfword, 2 means word.
REQ-009 The block SHALL have port wstrb  input  4  byte write enables, used only when wr=1.
REQ-010 The block SHALL have port addr  input  32  byte address.
REQ-011 The block SHALL have port wdata  input  32  write data.
REQ-012 The block SHALL have port addr_ok  output  1  request accepted in this cycle when req=1.
REQ-013 The block SHALL have port data_ok  output  1  one-cycle response pulse.
REQ-014 The block SHALL have port rdata  output  32  read data, valid only while data_ok=1.

Function
REQ-015 A request SHALL be accepted in the cycle where req=1 and addr_ok=1; no other cycle counts as an acceptance.
REQ-016 addr_ok SHALL equal (outstanding count < OST_DEPTH), with no same-cycle bypass from a retiring entry.
REQ-017 The word index SHALL be addr[AW+1:2]; higher address bits SHALL be ignored; no alignment check is performed.
REQ-018 On an accepted write, every byte lane i with wstrb[i]=1 SHALL be written with wdata[8i+7:8i] at the acceptance edge; size is ignored for writes.
REQ-019 On an accepted read, the full addressed word SHALL be sampled at the acceptance edge (after any write in an earlier cycle) and held in the entry; size is ignored and the initiator extracts lanes.
REQ-020 Each accepted request SHALL enqueue one entry {is_wr, rdata, cnt}, with cnt loaded to LATENCY-1.
REQ-021 Every valid entry's cnt SHALL decrement by 1 per cycle, saturating at 0.
REQ-022 data_ok SHALL be 1 for exactly one cycle, when the head entry has cnt=0; the head SHALL dequeue on that edge.
REQ-023 A request accepted at edge T SHALL produce data_ok in the cycle after edge T+LATENCY-1 (exact, no jitter), because the response path has no backpressure.
REQ-024 Responses SHALL be in acceptance order; writes SHALL also return data_ok, and rdata is don't-care for them.
REQ-025 When enqueue and dequeue occur in the same cycle, the outstanding count SHALL be unchanged and both operations SHALL take effect.
REQ-026 Queue read/write pointers SHALL wrap modulo OST_DEPTH.
REQ-027 While the queue is full, req SHALL be ignored with no side effects, including no memory write.

Reset
REQ-028 While reset=1, addr_ok=0, data_ok=0, rdata=0, count=0, and the pointers SHALL be 0.
REQ-029 Reset mid-operation SHALL discard all outstanding entries and emit no data_ok for them.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 addr_ok SHALL rise in the first cycle after reset deasserts.

Structure
REQ-032 The size encodings (BYTE=0, HALF=1, WORD=2) and the LATENCY and OST_DEPTH defaults SHALL reside in the shared package used by the core.
REQ-033 The outstanding-request queue SHALL be a sub-module resp_queue (parameterised depth, entry width, count/full/empty outputs); the memory array and handshake logic SHALL stay in sram_like_resp.

Verification
REQ-034 Scenario 1: write addr=0x10, wstrb=4'hF, wdata=0xDEADBEEF accepted at edge 5 with LATENCY=2 -> data_ok pulses in the cycle after edge 6; a read of 0x10 then returns 0xDEADBEEF.
REQ-035 Scenario 2: mem[4]=0x11223344, write addr=0x10, wstrb=4'b0010, wdata=0x0000AA00 -> a subsequent read of 0x10 returns 0x1122AA44.
REQ-036 Scenario 3: req held high with LATENCY=3, OST_DEPTH=2 -> addr_ok drops after 2 accepts, and exactly 2 data_ok pulses occur in order before the 3rd accept.
REQ-037 Scenario 4: back-to-back reads of 0x0, 0x4, 0x8 with LATENCY=1 -> one accept per cycle, data_ok each cycle, rdata in address order.
REQ-038 Scenario 5: reset asserted one cycle after two accepts -> no data_ok appears, and addr_ok=1 in the first cycle after release.
REQ-039 Scenario 6: write to addr=0x40 immediately followed by a read of 0x1040 with AW=10 -> the read returns the written value (address aliasing).
